// File: rtl/video_vsync_write_scheduler.sv
// video_vsync_write_scheduler
//
// Sits between the FPro video bus and the video subsystem decoder.
// Frame-buffer writes (addr[AW-1]=1) are forwarded on the next cycle.
// Slot-register writes can be deferred into a FIFO. The FIFO is then released
// in a burst right after frame_start, so that sprite, OSD and bar updates
// never tear in the middle of a frame.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   video_cs/wr         upstream chip select / write strobe (accept = cs & wr)
//   video_addr          upstream word address (bit AW-1 selects frame buffer)
//   video_wr_data       upstream write data
//   frame_start         one-cycle pulse at start of frame
//   defer_en            1 = hold slot writes until frame start
//   clr_ovf             clears the sticky overflow flag
//   m_cs/m_wr           registered downstream strobes
//   m_addr/m_wr_data    registered downstream address/data (hold when idle)
//   pending             registered FIFO occupancy (0..DEPTH)
//   draining            high while the FSM is in DRAIN (state observation)
//   ovf                 sticky: a deferred write was dropped on a full FIFO
//
// Handshake: there is no back-pressure. A write is taken on every cycle with
// video_cs & video_wr. Downstream sees exactly one cycle of m_cs & m_wr per
// issued write.

module video_vsync_write_scheduler #(
    parameter int DEPTH = 16,
    parameter int AW    = 21,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       video_cs,
    input  logic                       video_wr,
    input  logic [AW-1:0]              video_addr,
    input  logic [DW-1:0]              video_wr_data,
    input  logic                       frame_start,
    input  logic                       defer_en,
    input  logic                       clr_ovf,
    output logic                       m_cs,
    output logic                       m_wr,
    output logic [AW-1:0]              m_addr,
    output logic [DW-1:0]              m_wr_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       draining,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state, state_next;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_next;
    logic [CW-1:0]       drain_cnt, drain_cnt_next;
    logic [AW+DW-1:0]    mem [DEPTH];

    logic accept, is_fb, fb_issue, direct, up_issue;
    logic push_req, full, push, pop, drop;

    always_comb begin
        accept   = video_cs & video_wr;
        is_fb    = video_addr[AW-1];
        fb_issue = accept & is_fb;
        // A slot write may bypass the FIFO only when nothing is queued or
        // draining; otherwise it would overtake older queued writes.
        direct   = accept & ~is_fb & ~defer_en & (count == '0) & (state == IDLE);
        up_issue = fb_issue | direct;
        push_req = accept & ~is_fb & ~direct;
        full     = (count == CW'(DEPTH));
        // Upstream issues own the output bus; the drain stalls for that cycle.
        pop      = (state == DRAIN) & ~up_issue & (drain_cnt != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push     = push_req & (~full | pop);
        drop     = push_req & ~push;
        count_next = count + CW'(push) - CW'(pop);
    end

    // Next-state logic. The drain snapshot includes a push in the same cycle,
    // so it is taken from count_next.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            IDLE: begin
                if ((frame_start | ~defer_en) && (count_next != '0)) begin
                    state_next     = DRAIN;
                    drain_cnt_next = count_next;
                end
            end
            DRAIN: begin
                if (pop) begin
                    drain_cnt_next = drain_cnt - CW'(1);
                    if (drain_cnt == CW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                drain_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            m_cs      <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wr_data <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            count     <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A drop in the same cycle as clr_ovf leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (up_issue) begin
                m_cs      <= 1'b1;
                m_wr      <= 1'b1;
                m_addr    <= video_addr;
                m_wr_data <= video_wr_data;
            end else if (pop) begin
                m_cs      <= 1'b1;
                m_wr      <= 1'b1;
                m_addr    <= mem[rd_ptr][AW+DW-1:DW];
                m_wr_data <= mem[rd_ptr][DW-1:0];
            end else begin
                m_cs <= 1'b0;
                m_wr <= 1'b0;
            end
        end
    end

    // The storage array needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {video_addr, video_wr_data};
        end
    end

    assign pending  = count;
    assign draining = (state == DRAIN);

endmodule

// File: tb/tb_video_vsync_write_scheduler.sv
module tb_video_vsync_write_scheduler;

  localparam int DEPTH = 16;
  localparam int AW    = 21;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          video_cs, video_wr;
  logic [AW-1:0] video_addr;
  logic [DW-1:0] video_wr_data;
  logic          frame_start, defer_en, clr_ovf;
  logic          m_cs, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data;
  logic [CW-1:0] pending;
  logic          draining, ovf;

  video_vsync_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .video_cs(video_cs), .video_wr(video_wr),
    .video_addr(video_addr), .video_wr_data(video_wr_data),
    .frame_start(frame_start), .defer_en(defer_en), .clr_ovf(clr_ovf),
    .m_cs(m_cs), .m_wr(m_wr), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .pending(pending), .draining(draining), .ovf(ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int checks_total = 0;
  int checks_pass  = 0;
  int n_issue      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every downstream issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && m_cs && m_wr) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("FAIL unexpected_issue: got addr 0x%0h data 0x%0h expected no issue", m_addr, m_wr_data);
      end else begin
        check("issue", 64'({m_addr, m_wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    video_cs      = 1'b1;
    video_wr      = 1'b1;
    video_addr    = a;
    video_wr_data = d;
    tick();
    video_cs = 1'b0;
    video_wr = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_empty(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks_total++;
      $display("FAIL drain_timeout: %0d writes still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  int n0;

  initial begin
    reset = 1'b1;
    video_cs = 1'b0; video_wr = 1'b0; video_addr = '0; video_wr_data = '0;
    frame_start = 1'b0; defer_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    check("rst_m_cs", 64'(m_cs), 64'd0);
    check("rst_m_wr", 64'(m_wr), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_draining", 64'(draining), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    tick();

    // FB write forwards with one cycle latency.
    expect_wr(21'h100010, 32'hABC);
    wr(21'h100010, 32'hABC);
    check("fb_m_cs", 64'(m_cs), 64'd1);
    check("fb_m_addr", 64'(m_addr), 64'h100010);
    check("fb_m_data", 64'(m_wr_data), 64'hABC);
    check("fb_pending", 64'(pending), 64'd0);
    tick();
    check("idle_m_cs", 64'(m_cs), 64'd0);
    check("idle_addr_hold", 64'(m_addr), 64'h100010);

    // Direct slot write when deferral is off and nothing is queued.
    expect_wr(21'h000004, 32'h55);
    wr(21'h000004, 32'h55);
    check("direct_m_cs", 64'(m_cs), 64'd1);
    check("direct_pending", 64'(pending), 64'd0);
    tick();

    // Three deferred slot writes, released by frame_start.
    defer_en = 1'b1;
    for (int i = 1; i <= 3; i++) wr(21'h000800, DW'(i));
    tick();
    check("defer3_pending", 64'(pending), 64'd3);
    check("defer3_no_issue", 64'(m_cs), 64'd0);
    for (int i = 1; i <= 3; i++) expect_wr(21'h000800, DW'(i));
    pulse_fs();
    check("defer3_draining", 64'(draining), 64'd1);
    wait_empty(20);
    tick();
    check("defer3_idle", 64'(draining), 64'd0);
    check("defer3_pending_end", 64'(pending), 64'd0);

    // Overflow: 17 writes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) wr(21'h000900 + AW'(i), 32'h100 + DW'(i));
    check("ovf_pending", 64'(pending), 64'd16);
    check("ovf_set", 64'(ovf), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    for (int i = 0; i < 16; i++) expect_wr(21'h000900 + AW'(i), 32'h100 + DW'(i));
    pulse_fs();
    wait_empty(40);
    tick();
    check("ovf_pending_end", 64'(pending), 64'd0);
    check("ovf_draining_end", 64'(draining), 64'd0);

    // FB write on the second drain cycle wins the bus; drain stalls one cycle.
    for (int i = 1; i <= 4; i++) wr(21'h000A00, 32'h200 + DW'(i));
    expect_wr(21'h000A00, 32'h201);
    expect_wr(21'h100020, 32'hF00D);
    for (int i = 2; i <= 4; i++) expect_wr(21'h000A00, 32'h200 + DW'(i));
    n0 = n_issue;
    pulse_fs();
    tick();
    wr(21'h100020, 32'hF00D);
    wait_empty(20);
    tick();
    check("conflict_issue_count", 64'(n_issue - n0), 64'd5);
    check("conflict_pending", 64'(pending), 64'd0);

    // Write arriving during DRAIN is not in the snapshot.
    wr(21'h000B00, 32'h21);
    wr(21'h000B00, 32'h22);
    expect_wr(21'h000B00, 32'h21);
    expect_wr(21'h000B00, 32'h22);
    pulse_fs();
    wr(21'h000B00, 32'h23);
    wait_empty(20);
    repeat (3) tick();
    check("late_pending", 64'(pending), 64'd1);
    check("late_draining", 64'(draining), 64'd0);
    expect_wr(21'h000B00, 32'h23);
    pulse_fs();
    wait_empty(20);
    tick();
    check("late_pending_end", 64'(pending), 64'd0);

    // Dropping defer_en releases the queue in order, ahead of the new write.
    for (int i = 1; i <= 3; i++) wr(21'h000C00, 32'h30 + DW'(i));
    for (int i = 1; i <= 4; i++) expect_wr(21'h000C00, 32'h30 + DW'(i));
    defer_en = 1'b0;
    wr(21'h000C00, 32'h34);
    wait_empty(20);
    tick();
    check("undefer_pending", 64'(pending), 64'd0);

    // Reset in the middle of a drain discards everything.
    defer_en = 1'b1;
    for (int i = 1; i <= 3; i++) wr(21'h000D00, 32'h40 + DW'(i));
    pulse_fs();
    reset = 1'b1;
    tick();
    check("mid_rst_m_cs", 64'(m_cs), 64'd0);
    check("mid_rst_m_wr", 64'(m_wr), 64'd0);
    check("mid_rst_m_addr", 64'(m_addr), 64'd0);
    check("mid_rst_m_data", 64'(m_wr_data), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_draining", 64'(draining), 64'd0);
    reset = 1'b0;
    defer_en = 1'b0;
    repeat (8) tick();
    check("post_rst_pending", 64'(pending), 64'd0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/video_vsync_write_scheduler.md
Name: video_vsync_write_scheduler

Overview:
- Sits between the FPro video bus (video_cs/wr/addr/wr_data from the I/O bridge) and the video subsystem decoder.
- Frame-buffer writes (addr[20]=1) forward immediately.
- Slot-register writes (addr[20]=0: sync, mouse, osd, ghost, gray, bar cores) are held in a FIFO while deferral is enabled. They are released in a burst right after frame_start, so sprite position, OSD and bar updates never tear mid-frame.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥2)
- AW, 21, video word address width
- DW, 32, write data width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- video_cs  input  1  upstream chip select
- video_wr  input  1  upstream write strobe; a write is accepted when video_cs&video_wr
- video_addr  input  AW  upstream word address
- video_wr_data  input  DW  upstream write data
- frame_start  input  1  one-cycle pulse at start of frame from frame counter
- defer_en  input  1  1 = defer slot writes to frame start
- clr_ovf  input  1  clears the ovf sticky bit
- m_cs  output  1  downstream chip select
- m_wr  output  1  downstream write strobe
- m_addr  output  AW  downstream address
- m_wr_data  output  DW  downstream data
- pending  output  $clog2(DEPTH)+1  FIFO occupancy
- draining  output  1  high while in DRAIN state
- ovf  output  1  sticky: deferred write dropped because FIFO full

Behaviour:
- Single clock domain. Synchronous active-high reset.
- Reset values: m_cs=0, m_wr=0, m_addr=0, m_wr_data=0, pending=0, draining=0, ovf=0, state=IDLE, FIFO pointers=0, drain_cnt=0. Reset mid-drain discards all queued writes.
- All m_* outputs are registered, so forwarding latency is 1 cycle. In cycles with no issue, m_cs=m_wr=0 and m_addr/m_wr_data hold their previous values.
- Classification of an accepted write:
  - FB write (addr[20]=1): issued next cycle, always.
  - Slot write: issued directly next cycle only if defer_en=0, FIFO empty and state=IDLE. Otherwise it is pushed to the FIFO, which preserves order after defer_en drops.
- Push when FIFO full: dropped unless a pop occurs in the same cycle. On drop, ovf<=1. clr_ovf clears ovf; if a drop and clr_ovf coincide, the set wins.
- FSM:
  - IDLE: on frame_start with pending>0, load drain_cnt<=pending (the snapshot includes a push in the same cycle) and go to DRAIN. Also go to DRAIN when defer_en=0 and pending>0, with drain_cnt<=pending.
  - DRAIN: draining=1. Each cycle with no upstream FB/direct issue, pop the head, issue it on m_*, and decrement drain_cnt. When drain_cnt reaches 0 after a pop, return to IDLE. Writes pushed during DRAIN are not in the snapshot and wait for the next frame_start, or for the defer_en=0 rule.
  - frame_start during DRAIN is ignored (no reload).
- Output bus conflict: an upstream FB write or direct slot write wins. The pop stalls that cycle; the FIFO is unchanged and drain_cnt holds.
- Pop and push in the same cycle: occupancy is unchanged and both take effect, including when the FIFO is full.
- pending is the registered occupancy, updated the cycle after a push or pop.
- Pointers wrap modulo DEPTH. pending ranges 0..DEPTH.
- Toggling defer_en never reorders writes and never drops a queued entry.

Test Plan:
- Reset, then FB write addr=0x100010 data=0xABC → m_cs=m_wr=1, m_addr=0x100010, m_wr_data=0xABC exactly 1 cycle later; pending=0.
- defer_en=1, slot writes addr=0x000800 data=1,2,3 → no m_cs; pending=3. frame_start → draining=1 next cycle; data 1,2,3 on 3 consecutive cycles; then IDLE, pending=0.
- defer_en=1, 17 slot writes with DEPTH=16 and no frame_start → pending=16, ovf=1, 17th dropped. clr_ovf → ovf=0. frame_start drains exactly 16 entries in order.
- During DRAIN of 4 entries, inject FB write on 2nd drain cycle → FB write issued that cycle; drain stalls one cycle; total 5 issue cycles, queue order intact.
- 2 queued, frame_start, then slot write during DRAIN → only 2 issued, pending=1 afterwards. Next frame_start issues the third.
- 3 queued, defer_en 1→0, then new slot write → the 3 queued issue first, then the new write; no reordering. Assert reset mid-drain → all outputs 0, pending=0 next cycle.
